chacha_block_ctrl: RTL

- Sequences one shared `quarter_round` datapath instance to produce one 512-bit ChaCha keystream block.
- Builds the 16-word initial state from constants, key, block counter and nonce.
- Runs ROUNDS rounds, alternating column and diagonal, one quarter-round per cycle, then applies the feed-forward addition.
- Sits between the key/nonce front end and the XOR/stream stage, with valid/ready handshakes on both sides.

---
 rtl/chacha_pkg.sv | 39 +++
 rtl/quarter_round.sv | 32 +++
 rtl/chacha_block_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared types, constants and index tables for the ChaCha block controller.
package chacha_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned QR_W      = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [NUM_WORDS-1:0] state_t;

  localparam word_t CHACHA_CONST [4] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
  };

  // Word indices (a,b,c,d) per quarter-round slot: 0-3 columns, 4-7 diagonals.
  localparam logic [IDX_W-1:0] QR_IDX [8][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15},
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } fsm_t;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/quarter_round.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module quarter_round
  import chacha_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_c,
  output logic [31:0] b_c,
  output logic [31:0] c_c,
  output logic [31:0] d_c
);

  word_t a1, b1, c1, d1;
  word_t a2, b2, c2, d2;

  assign a1 = a + b;
  assign d1 = rotl(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl(b ^ c1, 12);
  assign a2 = a1 + b1;
  assign d2 = rotl(d1 ^ a2, 8);
  assign c2 = c1 + d2;
  assign b2 = rotl(b1 ^ c2, 7);

  assign a_c = a2;
  assign b_c = b2;
  assign c_c = c2;
  assign d_c = d2;

endmodule

// File: rtl/chacha_block_ctrl.sv
// Sequences one shared quarter_round over ROUNDS rounds and adds the feed-forward
// to produce one 512-bit ChaCha keystream block per request.
module chacha_block_ctrl
  import chacha_pkg::*;
#(
  parameter int unsigned ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic         busy
);

  if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
    $error("chacha_block_ctrl: ROUNDS must be even and at least 2");
  end

  localparam int unsigned DR_W = $clog2(ROUNDS / 2 + 1);
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(ROUNDS / 2 - 1);

  fsm_t             fsm;
  state_t           st;
  state_t           init_st;
  state_t           init_c;
  state_t           ff_c;
  logic [QR_W-1:0]  qr_idx;
  logic [DR_W-1:0]  dr_cnt;
  logic [IDX_W-1:0] idx_a, idx_b, idx_c, idx_d;
  word_t            qa_c, qb_c, qc_c, qd_c;

  // Initial state image: constants, key, counter, nonce.
  always_comb begin
    init_c = '0;
    for (int i = 0; i < 4; i++) init_c[i] = CHACHA_CONST[i];
    for (int i = 0; i < 8; i++) init_c[4+i] = key[32*i +: 32];
    init_c[12] = counter;
    for (int i = 0; i < 3; i++) init_c[13+i] = nonce[32*i +: 32];
  end

  // Feed-forward: word-wise modulo 2^32, no carry between words.
  always_comb begin
    ff_c = '0;
    for (int i = 0; i < 16; i++) ff_c[i] = st[i] + init_st[i];
  end

  always_comb begin
    idx_a = QR_IDX[qr_idx][0];
    idx_b = QR_IDX[qr_idx][1];
    idx_c = QR_IDX[qr_idx][2];
    idx_d = QR_IDX[qr_idx][3];
  end

  quarter_round u_qr (
    .a   (st[idx_a]),
    .b   (st[idx_b]),
    .c   (st[idx_c]),
    .d   (st[idx_d]),
    .a_c (qa_c),
    .b_c (qb_c),
    .c_c (qc_c),
    .d_c (qd_c)
  );

  // in_ready rises one cycle after IDLE is entered, so IDLE always lasts at least one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      st        <= '0;
      init_st   <= '0;
      qr_idx    <= '0;
      dr_cnt    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      keystream <= '0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            st       <= init_c;
            init_st  <= init_c;
            qr_idx   <= '0;
            dr_cnt   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            fsm      <= ROUND;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ROUND: begin
          st[idx_a] <= qa_c;
          st[idx_b] <= qb_c;
          st[idx_c] <= qc_c;
          st[idx_d] <= qd_c;
          qr_idx    <= qr_idx + QR_W'(1);
          if (qr_idx == QR_W'(7)) begin
            dr_cnt <= dr_cnt + DR_W'(1);
            if (dr_cnt == DR_LAST) fsm <= FINAL;
          end
        end
        FINAL: begin
          keystream <= ff_c;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          fsm       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
